// File: rtl/alu_pipe.sv
// Handshaked, registered ALU with an iterative shift-add multiplier.
// Optional {N,Z,C,V} status flags are generated when ALU_PIPE_FLAGS_EN is defined.
module alu_pipe #(
   parameter int WIDTH = 16,
   localparam int SHW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       opcode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic             busy
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_MUL = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_SHR = 3'b111;

`ifdef ALU_PIPE_FLAGS_EN
   localparam int ACCW = 2 * WIDTH;
`else
   localparam int ACCW = WIDTH;
`endif

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

   state_t           r_state, w_state_nxt;
   logic [SHW-1:0]   r_cnt;
   logic [ACCW-1:0]  r_acc, r_mcand, w_acc_nxt;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] r_result, w_alu_res, w_load_res;
   logic [SHW-1:0]   w_shamt;
   logic             w_in_ready, w_accept, w_is_mul, w_mul_last, w_load;

   assign w_accept   = in_valid && w_in_ready;
   assign w_is_mul   = (opcode == OP_MUL);
   assign w_mul_last = (r_state == S_MUL) && (r_cnt == '0);
   assign w_load     = (w_accept && !w_is_mul) || w_mul_last;
   assign w_shamt    = b[SHW-1:0];
   assign w_acc_nxt  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
   assign w_load_res = w_mul_last ? w_acc_nxt[WIDTH-1:0] : w_alu_res;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept)
            r_cnt <= SHW'(WIDTH - 1);
         else if (r_state == S_MUL)
            r_cnt <= r_cnt - 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_state_nxt = w_is_mul ? S_MUL : S_DONE;
         S_MUL:  if (r_cnt == '0) w_state_nxt = S_DONE;
         S_DONE: begin
            if (w_accept)
               w_state_nxt = w_is_mul ? S_MUL : S_DONE;
            else if (out_ready)
               w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_in_ready = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      case (r_state)
         S_IDLE: w_in_ready = 1'b1;
         S_MUL:  busy = 1'b1;
         S_DONE: begin
            out_valid  = 1'b1;
            w_in_ready = out_ready;
         end
         default: ;
      endcase
   end

   assign in_ready = w_in_ready;

   // Multiplier datapath: operands latched at accept, one shift-add per MUL cycle.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_acc    <= '0;
         r_mcand  <= ACCW'(a);
         r_mplier <= b;
      end else if (r_state == S_MUL) begin
         r_acc    <= w_acc_nxt;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
      end
   end

   always_comb begin
      w_alu_res = '0;
      case (opcode)
         OP_ADD:  w_alu_res = a + b;
         OP_SUB:  w_alu_res = a - b;
         OP_AND:  w_alu_res = a & b;
         OP_OR:   w_alu_res = a | b;
         OP_XOR:  w_alu_res = a ^ b;
         OP_SHL:  w_alu_res = a << w_shamt;
         OP_SHR:  w_alu_res = a >> w_shamt;
         default: w_alu_res = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_result <= '0;
      else if (w_load)
         r_result <= w_load_res;
   end

   assign result = r_result;

`ifdef ALU_PIPE_FLAGS_EN
   logic [3:0]     r_flags;
   logic [SHW-1:0] w_shl_idx, w_shr_idx;
   logic           w_alu_c, w_alu_v, w_mul_ovf, w_load_c, w_load_v;

   // WIDTH-s wraps to the right bit index because WIDTH is a power of two.
   assign w_shl_idx = -w_shamt;
   assign w_shr_idx = w_shamt - 1'b1;
   assign w_mul_ovf = (w_acc_nxt[ACCW-1:WIDTH] != '0);

   always_comb begin
      w_alu_c = 1'b0;
      w_alu_v = 1'b0;
      case (opcode)
         OP_ADD: begin
            w_alu_c = (w_alu_res < a);
            w_alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (w_alu_res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            w_alu_c = (a < b);
            w_alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (w_alu_res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SHL:  w_alu_c = (w_shamt != '0) && a[w_shl_idx];
         OP_SHR:  w_alu_c = (w_shamt != '0) && a[w_shr_idx];
         default: ;
      endcase
   end

   assign w_load_c = w_mul_last ? w_mul_ovf : w_alu_c;
   assign w_load_v = w_mul_last ? w_mul_ovf : w_alu_v;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_flags <= '0;
      else if (w_load)
         r_flags <= {w_load_res[WIDTH-1], (w_load_res == '0), w_load_c, w_load_v};
   end

   assign flags = r_flags;
`else
   assign flags = 4'b0000;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe (WIDTH=16); flag expectations collapse to 0
// when ALU_PIPE_FLAGS_EN is not defined.
module tb_alu_pipe;

   localparam int WIDTH = 16;
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_MUL = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_SHR = 3'b111;
`ifdef ALU_PIPE_FLAGS_EN
   localparam logic [3:0] FMASK = 4'hF;
`else
   localparam logic [3:0] FMASK = 4'h0;
`endif

   logic             clk = 1'b0;
   logic             rst_n, in_valid, in_ready, out_valid, out_ready, busy;
   logic [2:0]       opcode;
   logic [WIDTH-1:0] a, b, result;
   logic [3:0]       flags;

   int n_tests = 0;
   int n_fail  = 0;

   logic [WIDTH-1:0] xa [8] = '{16'h0000, 16'hFFFF, 16'h1234, 16'hAAAA,
                                16'h0F0F, 16'h8000, 16'hFFFF, 16'h5A5A};
   logic [WIDTH-1:0] xb [8] = '{16'h0000, 16'hFFFF, 16'h4321, 16'h5555,
                                16'hF0F0, 16'h0001, 16'h0000, 16'hA5A5};
   logic [WIDTH-1:0] xr [8] = '{16'h0000, 16'h0000, 16'h5115, 16'hFFFF,
                                16'hFFFF, 16'h8001, 16'hFFFF, 16'hFFFF};
   logic [3:0]       xf [8] = '{4'b0100, 4'b0100, 4'b0000, 4'b1000,
                                4'b1000, 4'b1000, 4'b1000, 4'b1000};

   alu_pipe #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; presents one op for exactly one rising edge.
   task automatic do_op(input logic [2:0] op, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
      opcode   = op;
      a        = va;
      b        = vb;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      int seen, cyc, nbusy, nblk, nstable;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      opcode = 3'b000; a = '0; b = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result",    32'(result),    32'd0);
      check("rst_flags",     32'(flags),     32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_busy",      32'(busy),      32'd0);

      // reset in the middle of a multiply
      @(negedge clk);
      do_op(OP_MUL, 16'd3, 16'd5);
      check("abort_mul_busy", 32'(busy), 32'd1);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy_in_reset", 32'(busy), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("abort_in_ready", 32'(in_ready),  32'd1);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      seen = 0;
      repeat (25) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("abort_no_result", 32'(seen), 32'd0);
      check("abort_result", 32'(result), 32'd0);

      do_op(OP_ADD, 16'h7FFF, 16'h0001);
      check("add_valid", 32'(out_valid), 32'd1);
      check("add_result", 32'(result), 32'h8000);
      check("add_flags", 32'(flags), 32'(4'b1001 & FMASK));

      do_op(OP_SUB, 16'h0003, 16'h0005);
      check("sub_result", 32'(result), 32'hFFFE);
      check("sub_flags", 32'(flags), 32'(4'b1010 & FMASK));

      do_op(OP_ADD, 16'hFFFF, 16'h0001);
      check("add_wrap_result", 32'(result), 32'h0000);
      check("add_wrap_flags", 32'(flags), 32'(4'b0110 & FMASK));

      do_op(OP_SHR, 16'h0003, 16'h0002);
      check("shr2_result", 32'(result), 32'h0000);
      check("shr2_flags", 32'(flags), 32'(4'b0110 & FMASK));

      // multiply; inputs are scrambled after accept to prove operand capture
      opcode = OP_MUL; a = 16'h0100; b = 16'h0100; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; opcode = OP_ADD; a = 16'hFFFF; b = 16'hFFFF;
      cyc = 1; nbusy = 0; nblk = 0;
      while (!out_valid && cyc < 40) begin
         if (busy) nbusy++;
         if (!in_ready) nblk++;
         @(negedge clk);
         cyc++;
      end
      check("mul_busy_cycles", 32'(nbusy), 32'd16);
      check("mul_in_ready_low", 32'(nblk), 32'd16);
      check("mul_out_valid_cycle", 32'(cyc), 32'd17);
      check("mul_result", 32'(result), 32'h0000);
      check("mul_flags", 32'(flags), 32'(4'b0111 & FMASK));

      do_op(OP_SHL, 16'h8001, 16'hFFF1);
      check("shl_result", 32'(result), 32'h0002);
      check("shl_flags", 32'(flags), 32'(4'b0010 & FMASK));

      // backpressure with a competing request that must not be taken
      out_ready = 1'b0;
      opcode = OP_ADD; a = 16'h1111; b = 16'h1111; in_valid = 1'b1;
      nstable = 0;
      repeat (5) begin
         @(negedge clk);
         if (result === 16'h0002 && in_ready === 1'b0 && out_valid === 1'b1 &&
             flags === (4'b0010 & FMASK)) nstable++;
      end
      check("hold_stable_cycles", 32'(nstable), 32'd5);
      out_ready = 1'b1;
      do_op(OP_SHR, 16'h0001, 16'h0000);
      check("shr0_valid", 32'(out_valid), 32'd1);
      check("shr0_result", 32'(result), 32'h0001);
      check("shr0_flags", 32'(flags), 32'(4'b0000 & FMASK));

      // back-to-back xor stream, one result per cycle
      for (int i = 0; i < 8; i++) begin
         opcode = OP_XOR; a = xa[i]; b = xb[i]; in_valid = 1'b1;
         @(posedge clk);
         @(negedge clk);
         check($sformatf("xor%0d_valid", i), 32'(out_valid), 32'd1);
         check($sformatf("xor%0d_result", i), 32'(result), 32'(xr[i]));
         check($sformatf("xor%0d_flags", i), 32'(flags), 32'(xf[i] & FMASK));
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("drain_out_valid", 32'(out_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
